// File: rtl/cia_pkg.sv
// Shared constants and helpers for the CIA time-of-day tick generator
// and the pin synchroniser/debounce blocks reused elsewhere in the CIA.
package cia_pkg;

   localparam int CIA_DIV_PAL  = 141876;
   localparam int CIA_DIV_NTSC = 119318;
   localparam int CIA_DIV_W    = 18;
   localparam int CIA_FILT_LEN = 4;
   localparam int CIA_WD_MULT  = 2;

   function automatic int cia_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cia_sync_filter.sv
// Two-flop synchroniser, polarity correction and run-length debounce for an
// asynchronous CIA input pin; level only moves after FILT_LEN agreeing samples.
module cia_sync_filter import cia_pkg::*; #(
   parameter int FILT_LEN = CIA_FILT_LEN
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic din,
   input  logic pol,
   output logic level
);

   logic       sync1_r;
   logic       sync2_r;
   logic       level_r;
   logic [3:0] cnt_r;
   logic       samp_s;

   assign samp_s = sync2_r ^ pol;
   assign level  = level_r;

   // Synchroniser chain plus debounce counter; a partial run is lost on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         cnt_r   <= 4'd0;
      end else if (en) begin
         sync1_r <= din;
         sync2_r <= sync1_r;
         if (samp_s == level_r) begin
            cnt_r <= 4'd0;
         end else if (cnt_r == 4'(FILT_LEN - 1)) begin
            level_r <= samp_s;
            cnt_r   <= 4'd0;
         end else begin
            cnt_r <= cnt_r + 4'd1;
         end
      end
   end

endmodule

// File: rtl/cia_tod_tick.sv
// TOD count strobe generator: picks a debounced external tick or an internal
// 50/60 Hz prescaler, and flags a missing external tick via a watchdog.
module cia_tod_tick import cia_pkg::*; #(
   parameter int DIV_PAL  = CIA_DIV_PAL,
   parameter int DIV_NTSC = CIA_DIV_NTSC,
   parameter int DIV_W    = CIA_DIV_W,
   parameter int FILT_LEN = CIA_FILT_LEN,
   parameter int WD_MULT  = CIA_WD_MULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clk7_en,
   input  logic tick_in,
   input  logic tick_pol,
   input  logic src_int,
   input  logic pal,
   output logic count,
   output logic tick_lost,
   output logic level
);

   localparam int WD_MAX = WD_MULT * cia_max(DIV_PAL, DIV_NTSC);
   localparam int WD_W   = $clog2(WD_MAX + 1);

   logic [DIV_W-1:0] presc_r;
   logic [DIV_W-1:0] div_last_s;
   logic [WD_W-1:0]  wd_r;
   logic [WD_W-1:0]  wd_lim_s;
   logic [WD_W-1:0]  wd_next_s;
   logic             level_s;
   logic             level_d_r;
   logic             src_int_d_r;
   logic             count_r;
   logic             tick_lost_r;
   logic             ext_edge_s;
   logic             int_tick_s;
   logic             switch_s;

   cia_sync_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_sync_filter (
      .clk   (clk),
      .reset (reset),
      .en    (clk7_en),
      .din   (tick_in),
      .pol   (tick_pol),
      .level (level_s)
   );

   assign div_last_s = pal ? DIV_W'(DIV_PAL - 1) : DIV_W'(DIV_NTSC - 1);
   assign wd_lim_s   = pal ? WD_W'(WD_MULT * DIV_PAL) : WD_W'(WD_MULT * DIV_NTSC);
   assign ext_edge_s = level_s & ~level_d_r;
   assign int_tick_s = (presc_r >= div_last_s);
   assign switch_s   = src_int ^ src_int_d_r;

   // Watchdog next value; clamps down too when pal shrinks the window.
   always_comb begin
      wd_next_s = wd_r;
      if (src_int || ext_edge_s) begin
         wd_next_s = {WD_W{1'b0}};
      end else if (wd_r >= wd_lim_s) begin
         wd_next_s = wd_lim_s;
      end else begin
         wd_next_s = wd_r + WD_W'(1);
      end
   end

   // Prescaler, source mux and watchdog state; a source switch kills that cycle's tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_r     <= {DIV_W{1'b0}};
         wd_r        <= {WD_W{1'b0}};
         level_d_r   <= 1'b0;
         src_int_d_r <= 1'b0;
         count_r     <= 1'b0;
         tick_lost_r <= 1'b0;
      end else if (clk7_en) begin
         src_int_d_r <= src_int;
         level_d_r   <= level_s;
         wd_r        <= wd_next_s;
         tick_lost_r <= ~src_int & (wd_next_s == wd_lim_s);
         if (switch_s || !src_int || int_tick_s) begin
            presc_r <= {DIV_W{1'b0}};
         end else begin
            presc_r <= presc_r + DIV_W'(1);
         end
         if (switch_s) begin
            count_r <= 1'b0;
         end else if (src_int) begin
            count_r <= int_tick_s;
         end else begin
            count_r <= ext_edge_s;
         end
      end
   end

   assign count     = count_r;
   assign tick_lost = tick_lost_r;
   assign level     = level_s;

endmodule

// File: tb/tb_cia_tod_tick.sv
// Self-checking bench for cia_tod_tick: directed scenarios followed by random
// stimulus, all checked against a cycle-level behavioural reference model.
module tb_cia_tod_tick;

   localparam int DIV_PAL  = 10;
   localparam int DIV_NTSC = 8;
   localparam int FILT_LEN = 3;
   localparam int WD_MULT  = 2;

   logic clk      = 1'b0;
   logic reset    = 1'b1;
   logic clk7_en  = 1'b0;
   logic tick_in  = 1'b0;
   logic tick_pol = 1'b0;
   logic src_int  = 1'b0;
   logic pal      = 1'b1;
   logic count;
   logic tick_lost;
   logic level;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state
   bit m_count, m_lost, m_level, m_rose, m_src_prev;
   int m_run, m_elapsed, m_quiet;
   bit m_hist[$];

   // per-scenario observations
   int seg_step, pulse_cnt, first_pulse, level_step, lost_step, lost_at_pulse;
   int run_left;

   cia_tod_tick #(
      .DIV_PAL  (DIV_PAL),
      .DIV_NTSC (DIV_NTSC),
      .DIV_W    (18),
      .FILT_LEN (FILT_LEN),
      .WD_MULT  (WD_MULT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clk7_en   (clk7_en),
      .tick_in   (tick_in),
      .tick_pol  (tick_pol),
      .src_int   (src_int),
      .pal       (pal),
      .count     (count),
      .tick_lost (tick_lost),
      .level     (level)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic chk_eq(input string tag, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (scenario step %0d)", tag, act, exp, seg_step);
      end
   endtask

   task automatic model_reset();
      m_count    = 1'b0;
      m_lost     = 1'b0;
      m_level    = 1'b0;
      m_rose     = 1'b0;
      m_src_prev = 1'b0;
      m_run      = 0;
      m_elapsed  = 0;
      m_quiet    = 0;
      m_hist     = {1'b0, 1'b0};
   endtask

   // One enabled cycle of the specified behaviour, from the inputs seen at that edge.
   task automatic model_step();
      int div, lim;
      bit sw, pend, it, s;
      div  = pal ? DIV_PAL : DIV_NTSC;
      lim  = WD_MULT * div;
      sw   = (src_int != m_src_prev);
      pend = m_rose;
      it   = 1'b0;
      if (sw || !src_int) begin
         m_elapsed = 0;
      end else begin
         m_elapsed++;
         if (m_elapsed >= div) begin
            it        = 1'b1;
            m_elapsed = 0;
         end
      end
      m_count = sw ? 1'b0 : (src_int ? it : pend);
      if (src_int || pend) m_quiet = 0;
      else m_quiet = (m_quiet + 1 < lim) ? m_quiet + 1 : lim;
      m_lost = !src_int && (m_quiet == lim);
      s = m_hist[0] ^ tick_pol;
      void'(m_hist.pop_front());
      m_hist.push_back(tick_in);
      m_rose = 1'b0;
      if (s != m_level) begin
         m_run++;
         if (m_run == FILT_LEN) begin
            m_level = s;
            m_run   = 0;
            m_rose  = s;
         end
      end else begin
         m_run = 0;
      end
      m_src_prev = src_int;
   endtask

   task automatic check_outputs(input string tag);
      chk_eq({tag, "_count"}, count, m_count);
      chk_eq({tag, "_lost"}, tick_lost, m_lost);
      chk_eq({tag, "_level"}, level, m_level);
   endtask

   task automatic seg_begin();
      seg_step      = 0;
      pulse_cnt     = 0;
      first_pulse   = -1;
      level_step    = -1;
      lost_step     = -1;
      lost_at_pulse = -1;
   endtask

   // One enabled clock followed by one disabled clock where everything must hold.
   task automatic step();
      clk7_en = 1'b1;
      @(posedge clk);
      model_step();
      #1;
      seg_step++;
      check_outputs("en");
      if (count === 1'b1) begin
         pulse_cnt++;
         if (first_pulse < 0) begin
            first_pulse   = seg_step;
            lost_at_pulse = tick_lost;
         end
      end
      if (level === 1'b1 && level_step < 0) level_step = seg_step;
      if (tick_lost === 1'b1 && lost_step < 0) lost_step = seg_step;
      clk7_en = 1'b0;
      @(posedge clk);
      #1;
      check_outputs("hold");
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Reset pulse placed between clock edges.
   task automatic async_reset();
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_outputs("rst");
      #2 reset = 1'b0;
   endtask

   initial begin
      model_reset();
      seg_begin();
      #12;
      chk_eq("reset_count", count, 0);
      chk_eq("reset_lost", tick_lost, 0);
      chk_eq("reset_level", level, 0);
      #1 reset = 1'b0;

      // clean external tick
      src_int = 1'b0; tick_pol = 1'b0; pal = 1'b1; tick_in = 1'b0;
      run(4);
      seg_begin(); tick_in = 1'b1; run(20);
      chk_eq("ext_pulses", pulse_cnt, 1);
      chk_eq("ext_latency", first_pulse, 6);
      chk_eq("ext_level_latency", level_step, 5);

      // glitch rejection
      tick_in = 1'b0; run(10);
      seg_begin(); tick_in = 1'b1; run(2); tick_in = 1'b0; run(10);
      chk_eq("glitch2_pulses", pulse_cnt, 0);
      chk_eq("glitch2_level", level_step, -1);
      seg_begin(); tick_in = 1'b1; run(3); tick_in = 1'b0; run(10);
      chk_eq("pulse3_pulses", pulse_cnt, 1);
      chk_eq("pulse3_latency", first_pulse, 6);

      // internal prescaler, PAL then NTSC with prescaler at 9
      src_int = 1'b1; pal = 1'b1; run(1);
      seg_begin(); run(50);
      chk_eq("pal_pulses", pulse_cnt, 5);
      chk_eq("pal_first", first_pulse, 10);
      run(9);
      pal = 1'b0;
      seg_begin(); run(17);
      chk_eq("ntsc_pulses", pulse_cnt, 3);
      chk_eq("ntsc_first", first_pulse, 1);

      // source switch coinciding with an external edge
      src_int = 1'b0; pal = 1'b1; tick_in = 1'b0; run(10);
      tick_in = 1'b1; run(5);
      src_int = 1'b1;
      seg_begin(); run(12);
      chk_eq("switch_pulses", pulse_cnt, 1);
      chk_eq("switch_first", first_pulse, 11);

      // watchdog
      src_int = 1'b0; pal = 1'b1;
      seg_begin(); run(22);
      chk_eq("wd_lost_step", lost_step, 20);
      chk_eq("wd_no_pulse", pulse_cnt, 0);
      tick_in = 1'b0; run(8);
      seg_begin(); tick_in = 1'b1; run(8);
      chk_eq("wd_edge_pulse", first_pulse, 6);
      chk_eq("wd_lost_at_pulse", lost_at_pulse, 0);
      chk_eq("wd_edge_count", pulse_cnt, 1);

      // async reset with count high and filter part-way
      src_int = 1'b1; tick_in = 1'b0; run(7);
      tick_in = 1'b1; run(4);
      chk_eq("pre_reset_count", count, 1);
      async_reset();
      src_int = 1'b0; tick_in = 1'b1;
      seg_begin(); run(8);
      chk_eq("post_reset_pulses", pulse_cnt, 1);
      chk_eq("post_reset_latency", first_pulse, 6);

      // random stimulus against the model
      run_left = 0;
      for (int i = 0; i < 600; i++) begin
         if (run_left == 0) begin
            tick_in  = ~tick_in;
            run_left = $urandom_range(1, 6);
         end
         run_left--;
         if ($urandom_range(0, 39) == 0) tick_pol = ~tick_pol;
         if ($urandom_range(0, 59) == 0) src_int = ~src_int;
         if ($urandom_range(0, 29) == 0) pal = ~pal;
         if ($urandom_range(0, 249) == 0) async_reset();
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
